// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_ctrl_if
//  Purpose  : Groups the instruction-memory bus, the redirect/halt controls
//             and the IF/ID valid/ready handshake of imem_fetch_ctrl.
//  Modports : master - the fetch controller (drives ImemAddress, Out*)
//             slave  - the surroundings (memory, branch unit, IF/ID stage)
//  Signals  : ImemAddress     [31:0] byte address to instruction memory
//             ImemInstruction [31:0] combinational read data for ImemAddress
//             Redirect               branch/jump taken, flush and reload PC
//             RedirectPC      [31:0] new PC (bits [1:0] ignored)
//             Halt                   stop fetching
//             OutValid               FIFO head holds a valid instruction
//             OutReady               IF/ID accepts the head this cycle
//             OutInstruction  [31:0] head instruction
//             OutPC           [31:0] PC of head instruction
//             OutPCPlus4      [31:0] OutPC + 4
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        Halt;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutInstruction;
   logic [31:0] OutPC;
   logic [31:0] OutPCPlus4;

   modport master (
      output ImemAddress,
      input  ImemInstruction,
      input  Redirect,
      input  RedirectPC,
      input  Halt,
      output OutValid,
      input  OutReady,
      output OutInstruction,
      output OutPC,
      output OutPCPlus4
   );

   modport slave (
      input  ImemAddress,
      output ImemInstruction,
      output Redirect,
      output RedirectPC,
      output Halt,
      input  OutValid,
      output OutReady,
      input  OutInstruction,
      input  OutPC,
      input  OutPCPlus4
   );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_ctrl
//  Purpose  : Instruction-fetch sequencer. Owns the PC, drives the address of
//             a zero-latency instruction memory, buffers {PC, instruction}
//             pairs in a DEPTH-entry FIFO and presents the head to IF/ID over
//             a valid/ready handshake. Supports redirect (flush + reload) and
//             a halt hold state that only redirect or reset leaves.
//  Ports    : Clk   - rising-edge clock
//             Rst   - synchronous active-low reset
//             bus   - imem_fetch_ctrl_if.master (memory, control, handshake)
//             FetchCount [31:0], StallCount [31:0], FlushCount [15:0]
//                   - performance counters, present only when the macro
//                     IMEM_FETCH_PERF_EN is defined
//  Params   : RESET_PC - word-aligned PC loaded on reset
//             DEPTH    - FIFO entries, power of two in 2..8
//  Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  wire logic             Clk,
   input  wire logic             Rst,
   imem_fetch_ctrl_if.master     bus
`ifdef IMEM_FETCH_PERF_EN
   ,
   output logic [31:0]           FetchCount,
   output logic [31:0]           StallCount,
   output logic [15:0]           FlushCount
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q;
   logic [CNT_W-1:0]  count_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW-1:0]     wr_ptr_q;

   logic [31:0]       instr_mem_q [DEPTH];
   logic [31:0]       pc_mem_q    [DEPTH];

   logic              push;
   logic              pop;
   logic              valid;
   logic [31:0]       redirect_pc;

   assign valid       = (count_q != '0);
   assign pop         = valid & bus.OutReady;
   // Low address bits are cleared by masking so every input bit is consumed.
   assign redirect_pc = bus.RedirectPC & 32'hFFFF_FFFC;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and push decision
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         ST_RUN: begin
            // A pop frees the head slot in the same cycle, so a full FIFO
            // can still accept a new word when the head leaves.
            push = !bus.Redirect && !bus.Halt && ((count_q < C_DEPTH) || pop);
            if (!bus.Redirect && bus.Halt) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Dropping Halt alone does not resume fetch.
            if (bus.Redirect) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // PC, FIFO pointers and occupancy
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (bus.Redirect) begin
         // Flush discards any same-cycle push and pop.
         pc_q     <= redirect_pc;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) begin
            pc_q     <= pc_q + 32'd4;
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // FIFO storage needs no reset: head outputs are gated by occupancy.
   always_ff @(posedge Clk) begin
      if (Rst && !bus.Redirect && push) begin
         instr_mem_q[wr_ptr_q] <= bus.ImemInstruction;
         pc_mem_q[wr_ptr_q]    <= pc_q;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.ImemAddress    = pc_q;
   assign bus.OutValid       = valid;
   assign bus.OutInstruction = valid ? instr_mem_q[rd_ptr_q] : 32'd0;
   assign bus.OutPC          = valid ? pc_mem_q[rd_ptr_q] : 32'd0;
   assign bus.OutPCPlus4     = valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;

`ifdef IMEM_FETCH_PERF_EN
   // -------------------------------------------------------------------------
   // Performance counters (wrap on overflow)
   // -------------------------------------------------------------------------
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (push) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if ((state_q == ST_RUN) && !push && !bus.Redirect && !bus.Halt) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (bus.Redirect && valid) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
         end
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch_ctrl
//  Purpose  : Directed self-checking bench for imem_fetch_ctrl. Instruction
//             memory returns word index * 3. A second instance with
//             RESET_PC = 32'hFFFF_FFF8 exercises PC wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

   logic Clk = 1'b0;
   logic Rst;
   int   checks = 0;
   int   errors = 0;

   always #5 Clk = ~Clk;

   imem_fetch_ctrl_if bus ();
   imem_fetch_ctrl_if bus_w ();

   assign bus.ImemInstruction   = (bus.ImemAddress >> 2) * 32'd3;
   assign bus_w.ImemInstruction = (bus_w.ImemAddress >> 2) * 32'd3;

`ifdef IMEM_FETCH_PERF_EN
   logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
   logic [15:0] flush_cnt, flush_cnt_w;
`endif

   imem_fetch_ctrl #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) u_dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .bus        (bus)
`ifdef IMEM_FETCH_PERF_EN
      ,
      .FetchCount (fetch_cnt),
      .StallCount (stall_cnt),
      .FlushCount (flush_cnt)
`endif
   );

   imem_fetch_ctrl #(
      .RESET_PC (32'hFFFF_FFF8),
      .DEPTH    (2)
   ) u_dut_wrap (
      .Clk        (Clk),
      .Rst        (Rst),
      .bus        (bus_w)
`ifdef IMEM_FETCH_PERF_EN
      ,
      .FetchCount (fetch_cnt_w),
      .StallCount (stall_cnt_w),
      .FlushCount (flush_cnt_w)
`endif
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] wrap_pc [3];
   logic [31:0] wrap_p4 [3];

   initial begin
      wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;
      wrap_p4[0] = 32'hFFFF_FFFC; wrap_p4[1] = 32'h0000_0000; wrap_p4[2] = 32'h0000_0004;

      Rst = 1'b0;
      bus.Redirect = 1'b0;   bus.RedirectPC = '0;   bus.Halt = 1'b0;   bus.OutReady = 1'b0;
      bus_w.Redirect = 1'b0; bus_w.RedirectPC = '0; bus_w.Halt = 1'b0; bus_w.OutReady = 1'b1;
      step(); step();

      // ---- reset state ----
      chk("rst_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("rst_addr",  bus.ImemAddress, 32'd0);
      chk("rst_pc",    bus.OutPC, 32'd0);
      chk("rst_instr", bus.OutInstruction, 32'd0);
      chk("rst_pc4",   bus.OutPCPlus4, 32'd0);
      chk("rst_addr_w", bus_w.ImemAddress, 32'hFFFF_FFF8);

      // ---- streaming with OutReady=1, plus wrap instance ----
      Rst = 1'b1;
      bus.OutReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("strm_valid%0d", i), {31'd0, bus.OutValid}, 32'd1);
         chk($sformatf("strm_pc%0d", i),    bus.OutPC, 32'(4 * i));
         chk($sformatf("strm_instr%0d", i), bus.OutInstruction, 32'(3 * i));
         chk($sformatf("strm_pc4_%0d", i),  bus.OutPCPlus4, 32'(4 * i + 4));
         if (i < 3) begin
            chk($sformatf("wrap_pc%0d", i),  bus_w.OutPC, wrap_pc[i]);
            chk($sformatf("wrap_pc4_%0d", i), bus_w.OutPCPlus4, wrap_p4[i]);
         end
      end

      // ---- backpressure ----
      Rst = 1'b0; bus.OutReady = 1'b0;
      step();
      Rst = 1'b1;
      repeat (5) step();
      chk("bp_valid", {31'd0, bus.OutValid}, 32'd1);
      chk("bp_pc",    bus.OutPC, 32'd0);
      chk("bp_instr", bus.OutInstruction, 32'd0);
      chk("bp_addr",  bus.ImemAddress, 32'd8);
`ifdef IMEM_FETCH_PERF_EN
      chk("bp_fetchcnt", fetch_cnt, 32'd2);
      chk("bp_stallcnt", stall_cnt, 32'd3);
`endif
      bus.OutReady = 1'b1;
      #1;
      chk("bp_rel_pc0", bus.OutPC, 32'd0);
      step();
      chk("bp_rel_pc4", bus.OutPC, 32'd4);
      chk("bp_rel_v4",  {31'd0, bus.OutValid}, 32'd1);
      step();
      chk("bp_rel_pc8", bus.OutPC, 32'd8);
      chk("bp_rel_v8",  {31'd0, bus.OutValid}, 32'd1);

      // ---- redirect with two buffered entries (8, 12) ----
      bus.OutReady = 1'b0; bus.Redirect = 1'b1; bus.RedirectPC = 32'h0000_0042;
      step();
      chk("rd_valid0", {31'd0, bus.OutValid}, 32'd0);
      chk("rd_addr",   bus.ImemAddress, 32'h0000_0040);
`ifdef IMEM_FETCH_PERF_EN
      chk("rd_flushcnt", {16'd0, flush_cnt}, 32'd1);
`endif
      bus.Redirect = 1'b0; bus.OutReady = 1'b1;
      step();
      chk("rd_valid1", {31'd0, bus.OutValid}, 32'd1);
      chk("rd_pc1",    bus.OutPC, 32'h0000_0040);
      chk("rd_instr1", bus.OutInstruction, 32'd48);
      step();
      chk("rd_pc2",    bus.OutPC, 32'h0000_0044);
      chk("rd_instr2", bus.OutInstruction, 32'd51);

      // ---- halt pulse at PC 12 ----
      Rst = 1'b0;
      step();
      Rst = 1'b1;
      step(); step(); step();
      chk("hl_addr12", bus.ImemAddress, 32'd12);
      chk("hl_pc8",    bus.OutPC, 32'd8);
      bus.Halt = 1'b1;
      step();
      bus.Halt = 1'b0;
      chk("hl_drained", {31'd0, bus.OutValid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("hl_hold_valid%0d", i), {31'd0, bus.OutValid}, 32'd0);
         chk($sformatf("hl_hold_addr%0d", i),  bus.ImemAddress, 32'd12);
      end
      bus.Redirect = 1'b1; bus.RedirectPC = 32'd0;
      step();
      bus.Redirect = 1'b0;
      chk("hl_rd_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("hl_rd_addr",  bus.ImemAddress, 32'd0);
      step();
      chk("hl_res_valid", {31'd0, bus.OutValid}, 32'd1);
      chk("hl_res_pc0",   bus.OutPC, 32'd0);
      step();
      chk("hl_res_pc4",   bus.OutPC, 32'd4);

      // ---- redirect + pop + full, then reset mid-stream ----
      Rst = 1'b0; bus.OutReady = 1'b0;
      step();
      Rst = 1'b1;
      step(); step(); step();
      chk("rf_full_valid", {31'd0, bus.OutValid}, 32'd1);
      chk("rf_full_addr",  bus.ImemAddress, 32'd8);
`ifdef IMEM_FETCH_PERF_EN
      chk("rf_fetchcnt0", fetch_cnt, 32'd2);
      chk("rf_stallcnt0", stall_cnt, 32'd1);
      chk("rf_flushcnt0", {16'd0, flush_cnt}, 32'd0);
`endif
      bus.OutReady = 1'b1; bus.Redirect = 1'b1; bus.RedirectPC = 32'h0000_0100;
      step();
      bus.Redirect = 1'b0;
      chk("rf_valid0", {31'd0, bus.OutValid}, 32'd0);
      chk("rf_addr",   bus.ImemAddress, 32'h0000_0100);
`ifdef IMEM_FETCH_PERF_EN
      chk("rf_flushcnt1", {16'd0, flush_cnt}, 32'd1);
      chk("rf_fetchcnt1", fetch_cnt, 32'd2);
`endif
      step();
      chk("rf_pc",    bus.OutPC, 32'h0000_0100);
      chk("rf_instr", bus.OutInstruction, 32'h0000_00C0);
      Rst = 1'b0;
      step();
      chk("mr_addr",  bus.ImemAddress, 32'd0);
      chk("mr_valid", {31'd0, bus.OutValid}, 32'd0);
      chk("mr_pc",    bus.OutPC, 32'd0);
      chk("mr_instr", bus.OutInstruction, 32'd0);
      chk("mr_pc4",   bus.OutPCPlus4, 32'd0);
`ifdef IMEM_FETCH_PERF_EN
      chk("mr_fetchcnt", fetch_cnt, 32'd0);
      chk("mr_stallcnt", stall_cnt, 32'd0);
      chk("mr_flushcnt", {16'd0, flush_cnt}, 32'd0);
`endif
      Rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
